// File: rtl/alu_sequencer.sv
// Command front end for the 8-bit bitslice ALU array: holds each slice op for a
// settle window before capture, and sequences MUL as shift-and-add over AND-lsb/ADD ops.
module alu_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_cin,
  output logic [7:0]  slc_x,
  output logic [7:0]  slc_y,
  output logic [3:0]  slc_op,
  output logic        slc_cin,
  output logic        slc_cin2c,
  output logic        slc_lsb_y,
  input  logic [7:0]  slc_z,
  input  logic        slc_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ANDL = 4'b0101;
  localparam logic [3:0] OP_CPL  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] LAST    = 4'(SETTLE);

  typedef enum logic [2:0] {IDLE, SLICE, MUL_AND, MUL_ADD, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  acc_hi_q, acc_hi_d;
  logic [7:0]  acc_lo_q, acc_lo_d;
  logic [7:0]  slc_x_q, slc_x_d;
  logic [7:0]  slc_y_q, slc_y_d;
  logic [3:0]  slc_op_q, slc_op_d;
  logic        slc_cin_q, slc_cin_d;
  logic        slc_cin2c_q, slc_cin2c_d;
  logic        slc_lsb_y_q, slc_lsb_y_d;
  logic [15:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        last;
  logic [2:0]  idx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      slc_x_q     <= '0;
      slc_y_q     <= '0;
      slc_op_q    <= '0;
      slc_cin_q   <= 1'b0;
      slc_cin2c_q <= 1'b0;
      slc_lsb_y_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      slc_x_q     <= slc_x_d;
      slc_y_q     <= slc_y_d;
      slc_op_q    <= slc_op_d;
      slc_cin_q   <= slc_cin_d;
      slc_cin2c_q <= slc_cin2c_d;
      slc_lsb_y_q <= slc_lsb_y_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    slc_x_d     = slc_x_q;
    slc_y_d     = slc_y_q;
    slc_op_d    = slc_op_q;
    slc_cin_d   = slc_cin_q;
    slc_cin2c_d = slc_cin2c_q;
    slc_lsb_y_d = slc_lsb_y_q;
    res_d       = res_q;
    carry_d     = carry_q;
    last        = (cnt_q == LAST);
    idx_nx      = idx_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d   = cmd_a;
          b_d   = cmd_b;
          cnt_d = '0;
          if (cmd_op == OP_MUL) begin
            state_d     = MUL_AND;
            acc_hi_d    = '0;
            acc_lo_d    = '0;
            idx_d       = '0;
            slc_x_d     = cmd_a;
            slc_op_d    = OP_ANDL;
            slc_lsb_y_d = cmd_b[0];
            slc_cin_d   = 1'b0;
            slc_cin2c_d = 1'b0;
          end else begin
            state_d     = SLICE;
            slc_x_d     = cmd_a;
            slc_y_d     = cmd_b;
            slc_op_d    = cmd_op;
            slc_cin_d   = cmd_cin;
            slc_cin2c_d = (cmd_op == OP_CPL);
            slc_lsb_y_d = 1'b0;
          end
        end
      end
      SLICE: begin
        if (last) begin
          res_d   = {8'h00, slc_z};
          carry_d = slc_cout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      MUL_AND: begin
        // The settled AND-lsb result is the partial product; it goes straight onto y.
        if (last) begin
          cnt_d       = '0;
          state_d     = MUL_ADD;
          slc_op_d    = OP_ADD;
          slc_x_d     = acc_hi_q;
          slc_y_d     = slc_z;
          slc_cin_d   = 1'b0;
          slc_lsb_y_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      MUL_ADD: begin
        if (last) begin
          cnt_d    = '0;
          acc_hi_d = {slc_cout, slc_z[7:1]};
          acc_lo_d = {slc_z[0], acc_lo_q[7:1]};
          idx_d    = idx_nx;
          if (idx_q == 3'd7) begin
            state_d = RESP;
            res_d   = {slc_cout, slc_z, acc_lo_q[7:1]};
            carry_d = 1'b0;
          end else begin
            state_d     = MUL_AND;
            slc_op_d    = OP_ANDL;
            slc_x_d     = a_q;
            slc_lsb_y_d = b_q[idx_nx];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = res_q;
  assign rsp_carry  = carry_q;
  assign slc_x      = slc_x_q;
  assign slc_y      = slc_y_q;
  assign slc_op     = slc_op_q;
  assign slc_cin    = slc_cin_q;
  assign slc_cin2c  = slc_cin2c_q;
  assign slc_lsb_y  = slc_lsb_y_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: zero-delay slice-array model, SETTLE=2 and SETTLE=1 instances,
// expected responses queued at accept and compared at the response handshake.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid  [2];
  logic        cmd_ready  [2];
  logic [3:0]  cmd_op     [2];
  logic [7:0]  cmd_a      [2];
  logic [7:0]  cmd_b      [2];
  logic        cmd_cin    [2];
  logic [7:0]  slc_x      [2];
  logic [7:0]  slc_y      [2];
  logic [3:0]  slc_op     [2];
  logic        slc_cin    [2];
  logic        slc_cin2c  [2];
  logic        slc_lsb_y  [2];
  logic [7:0]  slc_z      [2];
  logic        slc_cout   [2];
  logic [8:0]  arr_out    [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [15:0] rsp_result [2];
  logic        rsp_carry  [2];

  int total = 0;
  int bad   = 0;
  logic [16:0] sb_q [$];

  // Behavioural slice array: {cout, z}.
  function automatic logic [8:0] array_model(input logic [7:0] x, input logic [7:0] y,
                                             input logic [3:0] op, input logic cin,
                                             input logic cin2c, input logic lsb_y);
    case (op)
      4'b0000: return {1'b0, x} + {1'b0, y} + 9'(cin);
      4'b0101: return {1'b0, x & {8{lsb_y}}};
      4'b0111: return {1'b0, x | y};
      4'b1000: return {1'b0, ~x} + 9'(cin2c);
      default: return {1'b0, x} + {1'b0, ~y} + 9'(cin);
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_sequencer #(.SETTLE(gi == 0 ? 2 : 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid[gi]),
      .cmd_ready  (cmd_ready[gi]),
      .cmd_op     (cmd_op[gi]),
      .cmd_a      (cmd_a[gi]),
      .cmd_b      (cmd_b[gi]),
      .cmd_cin    (cmd_cin[gi]),
      .slc_x      (slc_x[gi]),
      .slc_y      (slc_y[gi]),
      .slc_op     (slc_op[gi]),
      .slc_cin    (slc_cin[gi]),
      .slc_cin2c  (slc_cin2c[gi]),
      .slc_lsb_y  (slc_lsb_y[gi]),
      .slc_z      (slc_z[gi]),
      .slc_cout   (slc_cout[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_result (rsp_result[gi]),
      .rsp_carry  (rsp_carry[gi])
    );
    assign arr_out[gi]  = array_model(slc_x[gi], slc_y[gi], slc_op[gi], slc_cin[gi],
                                      slc_cin2c[gi], slc_lsb_y[gi]);
    assign slc_z[gi]    = arr_out[gi][7:0];
    assign slc_cout[gi] = arr_out[gi][8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] want, input string tag);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic chk_reset(input int s, input string tag);
    chk(32'(cmd_ready[s]), 32'd1, {tag, "_cmd_ready"});
    chk(32'(rsp_valid[s]), 32'd0, {tag, "_rsp_valid"});
    chk({15'd0, rsp_carry[s], rsp_result[s]}, 32'd0, {tag, "_rsp"});
    chk(32'({slc_x[s], slc_y[s], slc_op[s], slc_cin[s], slc_cin2c[s], slc_lsb_y[s]}),
        32'd0, {tag, "_slc"});
  endtask

  // One command through to its response; hold>0 delays rsp_ready that many clocks.
  task automatic run_cmd(input int s, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input int hold,
                         input int exp_lat, input logic [16:0] exp_rsp, input string tag);
    int n;
    logic bad_op, saw_c2c, stable_ok;
    logic [16:0] first, want;
    @(negedge clk);
    rsp_ready[s] = (hold == 0);
    cmd_valid[s] = 1'b1;
    cmd_op[s]    = op;
    cmd_a[s]     = a;
    cmd_b[s]     = b;
    cmd_cin[s]   = cin;
    chk(32'(cmd_ready[s]), 32'd1, {tag, "_accept_ready"});
    sb_q.push_back(exp_rsp);
    @(posedge clk);
    #1 cmd_valid[s] = 1'b0;
    n = 0; bad_op = 1'b0; saw_c2c = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      if (rsp_valid[s]) break;
      if (op == 4'b1001 && !(slc_op[s] == 4'b0101 || slc_op[s] == 4'b0000)) bad_op = 1'b1;
      if (slc_cin2c[s]) saw_c2c = 1'b1;
      @(posedge clk);
      n++;
    end
    chk(32'(n), 32'(exp_lat), {tag, "_latency"});
    chk(32'(saw_c2c), 32'(op == 4'b1000), {tag, "_cin2c"});
    if (op == 4'b1001) chk(32'(bad_op), 32'd0, {tag, "_mul_slc_op"});
    first = {rsp_carry[s], rsp_result[s]};
    stable_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      cmd_valid[s] = (k == 2);
      if (!rsp_valid[s] || cmd_ready[s] || {rsp_carry[s], rsp_result[s]} !== first)
        stable_ok = 1'b0;
      @(negedge clk);
    end
    cmd_valid[s] = 1'b0;
    if (hold > 0) chk(32'(stable_ok), 32'd1, {tag, "_backpressure_hold"});
    rsp_ready[s] = 1'b1;
    if (sb_q.size() == 0) begin
      chk(32'd0, 32'd1, {tag, "_scoreboard_empty"});
    end else begin
      want = sb_q.pop_front();
      chk({15'd0, rsp_carry[s], rsp_result[s]}, {15'd0, want}, {tag, "_result"});
    end
    $display("txn %s: inst=%0d op=%b a=%h b=%h lat=%0d result=%h carry=%0d", tag, s, op, a, b,
             n, rsp_result[s], rsp_carry[s]);
    @(negedge clk);
    chk(32'({rsp_valid[s], cmd_ready[s]}), 32'b01, {tag, "_back_to_idle"});
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cmd_valid[s] = 1'b0; cmd_op[s] = '0; cmd_a[s] = '0; cmd_b[s] = '0;
      cmd_cin[s] = 1'b0; rsp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset(0, "reset_s2");
    chk_reset(1, "reset_s1");

    run_cmd(0, 4'b0000, 8'h3C, 8'h0F, 1'b0, 0, 3,  17'h0004B, "add");
    run_cmd(0, 4'b1000, 8'h05, 8'h00, 1'b0, 0, 3,  17'h000FB, "cpl");
    run_cmd(0, 4'b1001, 8'hFF, 8'hFF, 1'b0, 0, 48, 17'h0FE01, "mul_ff_ff");
    run_cmd(0, 4'b1001, 8'h0D, 8'h0B, 1'b1, 0, 48, 17'h0008F, "mul_0d_0b");
    run_cmd(0, 4'b0000, 8'hF0, 8'h20, 1'b1, 5, 3,  17'h10011, "add_bp");
    repeat (4) @(negedge clk);
    chk(32'(rsp_valid[0]), 32'd0, "bp_pulse_ignored");

    // Abort a multiply partway through; no response may follow.
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    cmd_valid[0] = 1'b1; cmd_op[0] = 4'b1001; cmd_a[0] = 8'h5A; cmd_b[0] = 8'hC3;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset(0, "mid_mul_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(0, 4'b0111, 8'hA0, 8'h0A, 1'b0, 0, 3, 17'h000AA, "or_after_reset");

    run_cmd(1, 4'b0000, 8'h3C, 8'h0F, 1'b0, 0, 2,  17'h0004B, "add_s1");
    run_cmd(1, 4'b1001, 8'h12, 8'h34, 1'b0, 0, 32, 17'h003A8, "mul_s1");

    chk(32'(sb_q.size()), 32'd0, "scoreboard_drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
